// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC selection and fetch/decode/execute hazard control
// for the 8-bit pipelined processor. Boots the PC from memory word 0 over a
// req/ack port, then steers the PC register among sequential, jump, branch
// and (optionally) interrupt/return sources.
//
// Optional feature: define FETCH_SEQ_IRQ_EN to build the interrupt support
// (ISR state, epc, ie, irq_pend, irq/iret/irq_ack). Without it irq and iret
// are ignored and irq_ack is tied low.
module fetch_sequencer #(
  parameter int            AW      = 8,
  parameter logic [AW-1:0] IRQ_VEC = AW'(8'hF0)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          stall_in,
  input  logic          br_d,
  input  logic          jump,
  input  logic [AW-1:0] jump_target,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          iret,
  input  logic          irq,
  input  logic [AW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] pc_next,
  output logic          pc_en,
  output logic          stall_f,
  output logic          flush_d,
  output logic          flush_e,
  output logic          irq_ack
);

`ifdef FETCH_SEQ_IRQ_EN
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_ISR = 2'd2} state_t;
`else
  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;
`endif

  state_t        state;
  state_t        state_n;
  logic [AW-1:0] pc_inc;

`ifdef FETCH_SEQ_IRQ_EN
  logic [AW-1:0] epc;
  logic [AW-1:0] epc_n;
  logic          ie;
  logic          ie_n;
  logic          irq_pend;
  logic          pend_n;
  logic          take_irq;
  logic          take_iret;
`else
  // Interrupt inputs have no function in this build.
  logic          unused_irq_inputs;
  assign unused_irq_inputs = &{1'b0, irq, iret, br_d};
  assign irq_ack = 1'b0;
`endif

  // Sequential successor; wraps modulo 2^AW.
  assign pc_inc = pc_in + AW'(1);

  // State register: synchronous reset returns to BOOT with interrupts enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_BOOT;
`ifdef FETCH_SEQ_IRQ_EN
      epc      <= '0;
      ie       <= 1'b1;
      irq_pend <= 1'b0;
`endif
    end else begin
      state    <= state_n;
`ifdef FETCH_SEQ_IRQ_EN
      epc      <= epc_n;
      ie       <= ie_n;
      irq_pend <= pend_n;
`endif
    end
  end

  // Next-state logic: boot completion, interrupt latching, entry and return.
  always_comb begin
    state_n = state;
    if (state == S_BOOT && mem_ack) state_n = S_RUN;
`ifdef FETCH_SEQ_IRQ_EN
    epc_n  = epc;
    ie_n   = ie;
    pend_n = irq_pend;
    if (irq && ie) pend_n = 1'b1;
    // Entry consumes the pending request and masks further interrupts.
    if (take_irq) begin
      state_n = S_ISR;
      epc_n   = pc_in;
      ie_n    = 1'b0;
      pend_n  = 1'b0;
    end
    if (take_iret) begin
      state_n = S_RUN;
      ie_n    = 1'b1;
    end
`endif
  end

  // Output logic: Mealy next-PC priority mux plus stall/flush controls.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    pc_next  = pc_inc;
    pc_en    = 1'b0;
    stall_f  = 1'b1;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
`ifdef FETCH_SEQ_IRQ_EN
    irq_ack   = 1'b0;
    take_irq  = 1'b0;
    take_iret = 1'b0;
`endif
    if (!reset) begin
      if (state == S_BOOT) begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_next = mem_rdata;
          pc_en   = 1'b1;
        end
      end else begin
        pc_en = 1'b1;
        // Redirects outrank the load-use stall; a pending interrupt
        // waits behind any redirect, stall or control op in Decode.
        if (branch_taken) begin
          pc_next = branch_target;
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (jump) begin
          pc_next = jump_target;
          flush_d = 1'b1;
`ifdef FETCH_SEQ_IRQ_EN
        end else if (state == S_ISR && iret) begin
          pc_next   = epc;
          flush_d   = 1'b1;
          take_iret = 1'b1;
        end else if (state == S_RUN && irq_pend && !stall_in && !br_d) begin
          pc_next  = IRQ_VEC;
          flush_d  = 1'b1;
          irq_ack  = 1'b1;
          take_irq = 1'b1;
`endif
        end else if (stall_in) begin
          pc_en = 1'b0;
        end
        stall_f = ~pc_en;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a behavioural model checked on
// every cycle, plus hand-computed per-cycle expectations for directed cases.
// Works in both builds (FETCH_SEQ_IRQ_EN defined or not).
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc_in;
  logic       stall_in, br_d, jump, branch_taken, iret, irq, mem_ack;
  logic [7:0] jump_target, branch_target, mem_rdata;
  logic       mem_req, pc_en, stall_f, flush_d, flush_e, irq_ack;
  logic [7:0] mem_addr, pc_next;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .stall_in(stall_in), .br_d(br_d),
    .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .iret(iret), .irq(irq),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_addr(mem_addr), .pc_next(pc_next), .pc_en(pc_en), .stall_f(stall_f),
    .flush_d(flush_d), .flush_e(flush_e), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: what the block must remember between cycles.
  logic       m_boot = 1'b1;
  logic       m_isr  = 1'b0;
  logic [7:0] m_epc  = 8'h00;
  logic       m_ie   = 1'b1;
  logic       m_pend = 1'b0;

  // Model outputs for the current cycle.
  logic       e_req, e_en, e_stf, e_fd, e_fe, e_ack, e_iret;
  logic [7:0] e_next;
  logic [7:0] q_next;
  logic       q_en;

  // Hand-computed expectations for the current cycle.
  logic       l_on = 1'b0;
  logic       l_req, l_en, l_stf, l_fd, l_fe, l_ack;
  logic [7:0] l_next;
  logic       follow = 1'b1;

  always_comb begin
    e_req  = 1'b0;
    e_next = pc_in + 8'd1;
    e_en   = 1'b0;
    e_stf  = 1'b1;
    e_fd   = 1'b0;
    e_fe   = 1'b0;
    e_ack  = 1'b0;
    e_iret = 1'b0;
    if (!reset) begin
      if (m_boot) begin
        e_req = 1'b1;
        if (mem_ack) begin
          e_next = mem_rdata;
          e_en   = 1'b1;
        end
      end else begin
        e_en = 1'b1;
        if (branch_taken) begin
          e_next = branch_target; e_fd = 1'b1; e_fe = 1'b1;
        end else if (jump) begin
          e_next = jump_target; e_fd = 1'b1;
        end else if (IRQ_EN && m_isr && iret) begin
          e_next = m_epc; e_fd = 1'b1; e_iret = 1'b1;
        end else if (IRQ_EN && !m_isr && m_pend && !stall_in && !br_d) begin
          e_next = 8'hF0; e_fd = 1'b1; e_ack = 1'b1;
        end else if (stall_in) begin
          e_en = 1'b0;
        end
        e_stf = !e_en;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Compare process: check every output each cycle, then advance the model.
  always @(negedge clk) begin
    chk("mem_req", mem_req, e_req);
    chk("mem_addr", mem_addr, 8'h00);
    chk("pc_next", pc_next, e_next);
    chk("pc_en", pc_en, e_en);
    chk("stall_f", stall_f, e_stf);
    chk("flush_d", flush_d, e_fd);
    chk("flush_e", flush_e, e_fe);
    chk("irq_ack", irq_ack, e_ack);
    if (l_on) begin
      chk("lit_mem_req", mem_req, l_req);
      chk("lit_pc_next", pc_next, l_next);
      chk("lit_pc_en", pc_en, l_en);
      chk("lit_stall_f", stall_f, l_stf);
      chk("lit_flush_d", flush_d, l_fd);
      chk("lit_flush_e", flush_e, l_fe);
      chk("lit_irq_ack", irq_ack, l_ack);
    end
    q_next <= e_next;
    q_en   <= e_en;
    if (reset) begin
      m_boot <= 1'b1; m_isr <= 1'b0; m_epc <= 8'h00; m_ie <= 1'b1; m_pend <= 1'b0;
    end else begin
      if (m_boot && mem_ack) m_boot <= 1'b0;
      if (e_ack) begin
        m_isr <= 1'b1; m_epc <= pc_in; m_ie <= 1'b0; m_pend <= 1'b0;
      end else if (IRQ_EN && irq && m_ie) begin
        m_pend <= 1'b1;
      end
      if (e_iret) begin
        m_isr <= 1'b0; m_ie <= 1'b1;
      end
    end
  end

  task automatic lit(input logic rq, input logic [7:0] nx, input logic en,
                     input logic sf, input logic fd, input logic fe, input logic ak);
    l_on = 1'b1; l_req = rq; l_next = nx; l_en = en;
    l_stf = sf; l_fd = fd; l_fe = fe; l_ack = ak;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    l_on = 1'b0;
    if (follow && q_en) pc_in = q_next;
  endtask

  initial begin
    reset = 1'b1; pc_in = 8'h00; stall_in = 0; br_d = 0; jump = 0;
    branch_taken = 0; iret = 0; irq = 0; mem_ack = 0;
    jump_target = 8'h00; branch_target = 8'h00; mem_rdata = 8'h00;

    // Boot: 2 reset cycles, 3 wait cycles, ack with M[0]=0x20.
    lit(0, 8'h01, 0, 1, 0, 0, 0); step();
    lit(0, 8'h01, 0, 1, 0, 0, 0); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lit(1, 8'h01, 0, 1, 0, 0, 0); step();
    end
    mem_ack = 1; mem_rdata = 8'h20;
    lit(1, 8'h20, 1, 1, 0, 0, 0); step();
    mem_ack = 0;
    lit(0, 8'h21, 1, 0, 0, 0, 0); step();
    lit(0, 8'h22, 1, 0, 0, 0, 0); step();
    // Stray ack after boot is ignored.
    mem_ack = 1; mem_rdata = 8'h99;
    lit(0, 8'h23, 1, 0, 0, 0, 0); step();
    mem_ack = 0;

    // Wrap.
    follow = 1'b0;
    pc_in = 8'hFF;
    lit(0, 8'h00, 1, 0, 0, 0, 0); step();

    // Priority: branch > jump > stall.
    pc_in = 8'h10; stall_in = 1; jump = 1; jump_target = 8'h40;
    branch_taken = 1; branch_target = 8'h80;
    lit(0, 8'h80, 1, 0, 1, 1, 0); step();
    branch_taken = 0;
    lit(0, 8'h40, 1, 0, 1, 0, 0); step();
    jump = 0;
    lit(0, 8'h11, 0, 1, 0, 0, 0); step();
    stall_in = 0;

    // Interrupt entry from pc 0x33 and return.
    pc_in = 8'h33; irq = 1;
    lit(0, 8'h34, 1, 0, 0, 0, 0); step();
    irq = 0;
    lit(0, IRQ_EN ? 8'hF0 : 8'h34, 1, 0, IRQ_EN, 0, IRQ_EN); step();
    pc_in = 8'hF0;
    lit(0, 8'hF1, 1, 0, 0, 0, 0); step();
    pc_in = 8'hF1; iret = 1;
    lit(0, IRQ_EN ? 8'h33 : 8'hF2, 1, 0, IRQ_EN, 0, 0); step();
    iret = 0;

    // ie restored after return: a fresh pulse is taken again.
    pc_in = 8'h33; irq = 1;
    lit(0, 8'h34, 1, 0, 0, 0, 0); step();
    irq = 0;
    lit(0, IRQ_EN ? 8'hF0 : 8'h34, 1, 0, IRQ_EN, 0, IRQ_EN); step();

    // Branch with iret in ISR: branch wins, still in ISR (irq masked).
    pc_in = 8'hF0; iret = 1; branch_taken = 1; branch_target = 8'h55;
    lit(0, 8'h55, 1, 0, 1, 1, 0); step();
    iret = 0; branch_taken = 0;
    pc_in = 8'h55; irq = 1;
    lit(0, 8'h56, 1, 0, 0, 0, 0); step();
    irq = 0;
    lit(0, 8'h56, 1, 0, 0, 0, 0); step();
    iret = 1;
    lit(0, IRQ_EN ? 8'h33 : 8'h56, 1, 0, IRQ_EN, 0, 0); step();
    iret = 0;

    // Deferral: br_d holds off entry for two cycles.
    pc_in = 8'h60; irq = 1; br_d = 1;
    lit(0, 8'h61, 1, 0, 0, 0, 0); step();
    irq = 0;
    lit(0, 8'h61, 1, 0, 0, 0, 0); step();
    br_d = 0;
    lit(0, IRQ_EN ? 8'hF0 : 8'h61, 1, 0, IRQ_EN, 0, IRQ_EN); step();

    // Second irq inside ISR is masked.
    pc_in = 8'hF0; irq = 1;
    lit(0, 8'hF1, 1, 0, 0, 0, 0); step();
    irq = 0;
    lit(0, 8'hF1, 1, 0, 0, 0, 0); step();

    // Reset inside ISR, reboot to 0x08; iret then means nothing.
    reset = 1; irq = 1;
    lit(0, 8'hF1, 0, 1, 0, 0, 0); step();
    reset = 0; irq = 0;
    lit(1, 8'hF1, 0, 1, 0, 0, 0); step();
    mem_ack = 1; mem_rdata = 8'h08;
    lit(1, 8'h08, 1, 1, 0, 0, 0); step();
    mem_ack = 0; pc_in = 8'h08;
    lit(0, 8'h09, 1, 0, 0, 0, 0); step();
    iret = 1;
    lit(0, 8'h09, 1, 0, 0, 0, 0); step();
    iret = 0;

    // Pending irq held off by stall is discarded by reset.
    irq = 1; stall_in = 1;
    lit(0, 8'h09, 0, 1, 0, 0, 0); step();
    irq = 0;
    lit(0, 8'h09, 0, 1, 0, 0, 0); step();
    reset = 1; stall_in = 0;
    lit(0, 8'h09, 0, 1, 0, 0, 0); step();
    reset = 0; mem_ack = 1; mem_rdata = 8'h0A;
    lit(1, 8'h0A, 1, 1, 0, 0, 0); step();
    mem_ack = 0; pc_in = 8'h0A;
    lit(0, 8'h0B, 1, 0, 0, 0, 0); step();
    lit(0, 8'h0B, 1, 0, 0, 0, 0); step();

    // Stall defers a pending irq until it drops.
    irq = 1; stall_in = 1;
    lit(0, 8'h0B, 0, 1, 0, 0, 0); step();
    irq = 0;
    lit(0, 8'h0B, 0, 1, 0, 0, 0); step();
    stall_in = 0;
    lit(0, IRQ_EN ? 8'hF0 : 8'h0B, 1, 0, IRQ_EN, 0, IRQ_EN); step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
